// File: rtl/dispatch_stage.sv
// -----------------------------------------------------------------------------
// dispatch_stage
//
// Single-entry pipeline stage between rename and the issue queue. Each
// accepted renamed instruction is captured in a hold register and offered
// to the issue queue one cycle later. The stage keeps a busy table with one
// bit per physical register, and records which ROB entry owns each pending
// preg. It tags every source with a "still pending" state on the way into
// the issue queue.
//
// Wakeups from two writeback ports clear busy bits. They also clear the
// pending state of the instruction that is being held, so no wakeup is lost
// while the issue queue stalls. A redirect flush kills a younger held
// instruction and releases the busy bits owned by younger instructions.
//
// Parameters
//   PREG_LOG   physical register index width
//   ROB_LOG    ROB index width (a separate wrap flag is also carried)
//   PAYLOAD_W  opaque payload width, passed through unmodified
//
// Ports
//   clock, reset_n                  clock (rising edge), async active-low reset
//   in_*                            renamed instruction from rename, in_ready back
//   enq_*                           registered instruction to the issue queue
//   enq_src1_state/enq_src2_state   1 = source operand still pending
//   wb0_*, wb1_*                    writeback wakeup ports
//   flush_*                         redirect flush with the ROB tag of the redirect
//   perf_dispatch_cnt               enq handshakes   (only with DISPATCH_PERF_CNT_EN)
//   perf_stall_cnt                  stalled in_valid cycles (only with DISPATCH_PERF_CNT_EN)
//
// Build option
//   `define DISPATCH_PERF_CNT_EN adds the two 32-bit performance counters.
// -----------------------------------------------------------------------------
module dispatch_stage #(
  parameter int PREG_LOG  = 6,
  parameter int ROB_LOG   = 6,
  parameter int PAYLOAD_W = 128
) (
  input  logic                 clock,
  input  logic                 reset_n,

  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PREG_LOG-1:0]  in_prs1,
  input  logic [PREG_LOG-1:0]  in_prs2,
  input  logic [PREG_LOG-1:0]  in_prd,
  input  logic                 in_src1_is_reg,
  input  logic                 in_src2_is_reg,
  input  logic                 in_need_to_wb,
  input  logic                 in_robidx_flag,
  input  logic [ROB_LOG-1:0]   in_robidx,
  input  logic [PAYLOAD_W-1:0] in_payload,

  output logic                 enq_valid,
  input  logic                 enq_ready,
  output logic [PREG_LOG-1:0]  enq_prs1,
  output logic [PREG_LOG-1:0]  enq_prs2,
  output logic [PREG_LOG-1:0]  enq_prd,
  output logic                 enq_src1_is_reg,
  output logic                 enq_src2_is_reg,
  output logic                 enq_need_to_wb,
  output logic                 enq_robidx_flag,
  output logic [ROB_LOG-1:0]   enq_robidx,
  output logic [PAYLOAD_W-1:0] enq_payload,
  output logic                 enq_src1_state,
  output logic                 enq_src2_state,

  input  logic                 wb0_valid,
  input  logic                 wb0_need_to_wb,
  input  logic [PREG_LOG-1:0]  wb0_prd,
  input  logic                 wb1_valid,
  input  logic                 wb1_need_to_wb,
  input  logic [PREG_LOG-1:0]  wb1_prd,

`ifdef DISPATCH_PERF_CNT_EN
  output logic [31:0]          perf_dispatch_cnt,
  output logic [31:0]          perf_stall_cnt,
`endif

  input  logic                 flush_valid,
  input  logic                 flush_robidx_flag,
  input  logic [ROB_LOG-1:0]   flush_robidx
);

  localparam int NPREG = 1 << PREG_LOG;

  logic                 out_valid;
  logic [NPREG-1:0]     busy;
  logic [NPREG-1:0]     busy_next;
  logic [NPREG-1:0]     wb_clr;
  logic [NPREG-1:0]     flush_clr;
  logic [ROB_LOG:0]     owner [NPREG];

  logic accept;
  logic enq_fire;
  logic hold_younger;
  logic src1_pending;
  logic src2_pending;
  logic hold_src1_hit;
  logic hold_src2_hit;

  // The wrap flag flips the sense of the index compare once the ROB pointer
  // has wrapped past the redirect point.
  function automatic logic is_younger(input logic             f_flag,
                                      input logic [ROB_LOG-1:0] f_idx,
                                      input logic             x_flag,
                                      input logic [ROB_LOG-1:0] x_idx);
    return (f_flag ^ x_flag) ^ (f_idx < x_idx);
  endfunction

  function automatic logic wake_hit(input logic                v,
                                    input logic                need,
                                    input logic [PREG_LOG-1:0] wp,
                                    input logic [PREG_LOG-1:0] p);
    return v & need & (wp == p);
  endfunction

  assign hold_younger = is_younger(flush_robidx_flag, flush_robidx,
                                   enq_robidx_flag, enq_robidx);
  assign enq_valid    = out_valid & ~(flush_valid & hold_younger);
  assign enq_fire     = enq_valid & enq_ready;
  assign in_ready     = (~out_valid | enq_ready) & ~flush_valid;
  assign accept       = in_valid & in_ready;

  // The lookup reads the table before this cycle's update. An instruction whose
  // source matches its own destination therefore sees the older producer.
  // A same-cycle wakeup is folded in so that the dispatched state is current.
  assign src1_pending = busy[in_prs1] & in_src1_is_reg
                      & ~wake_hit(wb0_valid, wb0_need_to_wb, wb0_prd, in_prs1)
                      & ~wake_hit(wb1_valid, wb1_need_to_wb, wb1_prd, in_prs1);
  assign src2_pending = busy[in_prs2] & in_src2_is_reg
                      & ~wake_hit(wb0_valid, wb0_need_to_wb, wb0_prd, in_prs2)
                      & ~wake_hit(wb1_valid, wb1_need_to_wb, wb1_prd, in_prs2);

  assign hold_src1_hit = wake_hit(wb0_valid, wb0_need_to_wb, wb0_prd, enq_prs1)
                       | wake_hit(wb1_valid, wb1_need_to_wb, wb1_prd, enq_prs1);
  assign hold_src2_hit = wake_hit(wb0_valid, wb0_need_to_wb, wb0_prd, enq_prs2)
                       | wake_hit(wb1_valid, wb1_need_to_wb, wb1_prd, enq_prs2);

  // NOTE: every signal written in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    wb_clr    = '0;
    flush_clr = '0;
    if (wb0_valid & wb0_need_to_wb) wb_clr[wb0_prd] = 1'b1;
    if (wb1_valid & wb1_need_to_wb) wb_clr[wb1_prd] = 1'b1;
    if (flush_valid) begin
      for (int p = 0; p < NPREG; p++)
        flush_clr[p] = is_younger(flush_robidx_flag, flush_robidx,
                                  owner[p][ROB_LOG], owner[p][ROB_LOG-1:0]);
    end
    busy_next = busy & ~wb_clr & ~flush_clr;
    // The set is applied last so that it wins over a same-cycle clear.
    if (accept & in_need_to_wb & (in_prd != '0)) busy_next[in_prd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // see pre-edge values, whatever order the blocks evaluate in.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      busy           <= '0;
      enq_src1_state <= 1'b0;
      enq_src2_state <= 1'b0;
    end else begin
      busy <= busy_next;
      if (accept) begin
        out_valid      <= 1'b1;
        enq_src1_state <= src1_pending;
        enq_src2_state <= src2_pending;
      end else begin
        if ((flush_valid & hold_younger) | enq_fire) out_valid <= 1'b0;
        if (hold_src1_hit) enq_src1_state <= 1'b0;
        if (hold_src2_hit) enq_src2_state <= 1'b0;
      end
    end
  end

  // NOTE: the payload fields and the owner table are deliberately left
  // without a reset. They are only read behind out_valid or a busy bit, and
  // not resetting them allows the owner table to be built as plain storage.
  always_ff @(posedge clock) begin
    if (accept) begin
      enq_prs1        <= in_prs1;
      enq_prs2        <= in_prs2;
      enq_prd         <= in_prd;
      enq_src1_is_reg <= in_src1_is_reg;
      enq_src2_is_reg <= in_src2_is_reg;
      enq_need_to_wb  <= in_need_to_wb;
      enq_robidx_flag <= in_robidx_flag;
      enq_robidx      <= in_robidx;
      enq_payload     <= in_payload;
      if (in_need_to_wb) owner[in_prd] <= {in_robidx_flag, in_robidx};
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_dispatch_cnt <= '0;
      perf_stall_cnt    <= '0;
    end else begin
      if (enq_fire)              perf_dispatch_cnt <= perf_dispatch_cnt + 32'd1;
      if (in_valid & ~in_ready)  perf_stall_cnt    <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_stage.sv
// -----------------------------------------------------------------------------
// tb_dispatch_stage
//
// Self-checking bench for dispatch_stage. A behavioural model keeps the held
// instruction as a record and the busy/owner state as plain arrays. The
// bench first runs directed scenarios with literal expectations, then drives
// randomized traffic. Each negative clock edge compares the DUT against the
// model. The perf counters are checked only when DISPATCH_PERF_CNT_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_dispatch_stage;

  localparam int P  = 6;
  localparam int R  = 6;
  localparam int W  = 128;
  localparam int NP = 1 << P;

  typedef logic [159:0] wide_t;

  typedef struct {
    logic [P-1:0] prs1, prs2, prd;
    logic         r1, r2, wb, flag;
    logic [R-1:0] idx;
    logic [W-1:0] payload;
    logic         s1, s2;
  } entry_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic         in_valid, in_ready;
  logic [P-1:0] in_prs1, in_prs2, in_prd;
  logic         in_src1_is_reg, in_src2_is_reg, in_need_to_wb;
  logic         in_robidx_flag;
  logic [R-1:0] in_robidx;
  logic [W-1:0] in_payload;
  logic         enq_valid, enq_ready;
  logic [P-1:0] enq_prs1, enq_prs2, enq_prd;
  logic         enq_src1_is_reg, enq_src2_is_reg, enq_need_to_wb;
  logic         enq_robidx_flag;
  logic [R-1:0] enq_robidx;
  logic [W-1:0] enq_payload;
  logic         enq_src1_state, enq_src2_state;
  logic         wb0_valid, wb0_need_to_wb, wb1_valid, wb1_need_to_wb;
  logic [P-1:0] wb0_prd, wb1_prd;
  logic         flush_valid, flush_robidx_flag;
  logic [R-1:0] flush_robidx;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0]  perf_dispatch_cnt, perf_stall_cnt;
`endif

  dispatch_stage #(.PREG_LOG(P), .ROB_LOG(R), .PAYLOAD_W(W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_prs1(in_prs1), .in_prs2(in_prs2), .in_prd(in_prd),
    .in_src1_is_reg(in_src1_is_reg), .in_src2_is_reg(in_src2_is_reg),
    .in_need_to_wb(in_need_to_wb),
    .in_robidx_flag(in_robidx_flag), .in_robidx(in_robidx),
    .in_payload(in_payload),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_prs1(enq_prs1), .enq_prs2(enq_prs2), .enq_prd(enq_prd),
    .enq_src1_is_reg(enq_src1_is_reg), .enq_src2_is_reg(enq_src2_is_reg),
    .enq_need_to_wb(enq_need_to_wb),
    .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx),
    .enq_payload(enq_payload),
    .enq_src1_state(enq_src1_state), .enq_src2_state(enq_src2_state),
    .wb0_valid(wb0_valid), .wb0_need_to_wb(wb0_need_to_wb), .wb0_prd(wb0_prd),
    .wb1_valid(wb1_valid), .wb1_need_to_wb(wb1_need_to_wb), .wb1_prd(wb1_prd),
`ifdef DISPATCH_PERF_CNT_EN
    .perf_dispatch_cnt(perf_dispatch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag),
    .flush_robidx(flush_robidx)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input wide_t act, input wide_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  entry_t      m_hold;
  bit          m_valid;
  bit          m_busy  [NP];
  bit [R:0]    m_owner [NP];
  int unsigned m_disp, m_stall;

  function automatic bit younger(bit xf, bit [R-1:0] xi);
    return (flush_robidx_flag ^ xf) ^ (flush_robidx < xi);
  endfunction

  function automatic bit woken(bit [P-1:0] p);
    return (wb0_valid && wb0_need_to_wb && wb0_prd == p) ||
           (wb1_valid && wb1_need_to_wb && wb1_prd == p);
  endfunction

  function automatic bit hold_killed();
    return m_valid && flush_valid && younger(m_hold.flag, m_hold.idx);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    bit     rdy, acc, fire;
    entry_t e;
    if (!reset_n) begin
      m_valid = 1'b0;
      for (int i = 0; i < NP; i++) m_busy[i] = 1'b0;
      m_disp  = 0;
      m_stall = 0;
    end else begin
      rdy  = (!m_valid || enq_ready) && !flush_valid;
      acc  = in_valid && rdy;
      fire = m_valid && !hold_killed() && enq_ready;
      if (fire) m_disp++;
      if (in_valid && !rdy) m_stall++;
      e.prs1 = in_prs1; e.prs2 = in_prs2; e.prd = in_prd;
      e.r1 = in_src1_is_reg; e.r2 = in_src2_is_reg; e.wb = in_need_to_wb;
      e.flag = in_robidx_flag; e.idx = in_robidx; e.payload = in_payload;
      e.s1 = m_busy[in_prs1] && in_src1_is_reg && !woken(in_prs1);
      e.s2 = m_busy[in_prs2] && in_src2_is_reg && !woken(in_prs2);
      for (int p = 0; p < NP; p++) begin
        if (flush_valid && younger(m_owner[p][R], m_owner[p][R-1:0])) m_busy[p] = 1'b0;
        if (woken(P'(p))) m_busy[p] = 1'b0;
      end
      if (acc && in_need_to_wb && in_prd != '0) begin
        m_busy[in_prd]  = 1'b1;
        m_owner[in_prd] = {in_robidx_flag, in_robidx};
      end
      if (acc) begin
        m_hold  = e;
        m_valid = 1'b1;
      end else if (hold_killed() || fire) begin
        m_valid = 1'b0;
      end else begin
        if (woken(m_hold.prs1)) m_hold.s1 = 1'b0;
        if (woken(m_hold.prs2)) m_hold.s2 = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------- compare
  always @(negedge clock) begin
    if (reset_n && cmp_en) begin
      check("in_ready", wide_t'(in_ready), wide_t'((!m_valid || enq_ready) && !flush_valid));
      check("enq_valid", wide_t'(enq_valid), wide_t'(m_valid && !hold_killed()));
      if (m_valid) begin
        check("enq_prs1", wide_t'(enq_prs1), wide_t'(m_hold.prs1));
        check("enq_prs2", wide_t'(enq_prs2), wide_t'(m_hold.prs2));
        check("enq_prd", wide_t'(enq_prd), wide_t'(m_hold.prd));
        check("enq_src1_is_reg", wide_t'(enq_src1_is_reg), wide_t'(m_hold.r1));
        check("enq_src2_is_reg", wide_t'(enq_src2_is_reg), wide_t'(m_hold.r2));
        check("enq_need_to_wb", wide_t'(enq_need_to_wb), wide_t'(m_hold.wb));
        check("enq_robidx", wide_t'({enq_robidx_flag, enq_robidx}),
              wide_t'({m_hold.flag, m_hold.idx}));
        check("enq_payload", wide_t'(enq_payload), wide_t'(m_hold.payload));
        check("enq_src1_state", wide_t'(enq_src1_state), wide_t'(m_hold.s1));
        check("enq_src2_state", wide_t'(enq_src2_state), wide_t'(m_hold.s2));
      end
`ifdef DISPATCH_PERF_CNT_EN
      check("perf_dispatch_cnt", wide_t'(perf_dispatch_cnt), wide_t'(m_disp));
      check("perf_stall_cnt", wide_t'(perf_stall_cnt), wide_t'(m_stall));
`endif
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_prs1 = '0; in_prs2 = '0; in_prd = '0;
    in_src1_is_reg = 0; in_src2_is_reg = 0; in_need_to_wb = 0;
    in_robidx_flag = 0; in_robidx = '0; in_payload = '0;
    enq_ready = 1;
    wb0_valid = 0; wb0_need_to_wb = 0; wb0_prd = '0;
    wb1_valid = 0; wb1_need_to_wb = 0; wb1_prd = '0;
    flush_valid = 0; flush_robidx_flag = 0; flush_robidx = '0;
  endtask

  task automatic send(input int s1, input bit r1, input int s2, input bit r2,
                      input int d, input bit wb, input bit fl, input int idx);
    in_valid = 1;
    in_prs1 = P'(s1); in_src1_is_reg = r1;
    in_prs2 = P'(s2); in_src2_is_reg = r2;
    in_prd = P'(d); in_need_to_wb = wb;
    in_robidx_flag = fl; in_robidx = R'(idx);
    in_payload = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic rand_inputs();
    send($urandom_range(0, 7), $urandom_range(0, 3) != 0,
         $urandom_range(0, 7), $urandom_range(0, 3) != 0,
         $urandom_range(0, 7), $urandom_range(0, 3) != 0,
         1'($urandom_range(0, 1)), $urandom_range(0, NP - 1));
    in_valid          = $urandom_range(0, 9) < 7;
    enq_ready         = $urandom_range(0, 3) != 0;
    wb0_valid         = $urandom_range(0, 2) == 0;
    wb0_need_to_wb    = $urandom_range(0, 3) != 0;
    wb0_prd           = P'($urandom_range(0, 7));
    wb1_valid         = $urandom_range(0, 2) == 0;
    wb1_need_to_wb    = $urandom_range(0, 3) != 0;
    wb1_prd           = P'($urandom_range(0, 7));
    flush_valid       = $urandom_range(0, 15) == 0;
    flush_robidx_flag = 1'($urandom_range(0, 1));
    flush_robidx      = R'($urandom_range(0, NP - 1));
  endtask

  initial begin
`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] stall0;
`endif
    idle();
    reset_n = 0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1;
    tick();
    cmp_en = 1;
    check("reset in_ready", wide_t'(in_ready), wide_t'(1));
    check("reset enq_valid", wide_t'(enq_valid), wide_t'(0));

    // Producer A writes p5. Consumer B reads p5, then wakes while held.
    send(0, 0, 0, 0, 5, 1, 0, 1); tick();
    send(5, 1, 0, 0, 0, 0, 0, 2); tick();
    check("B src1 pending", wide_t'(enq_src1_state), wide_t'(1));
    in_valid = 0; enq_ready = 0;
    wb0_valid = 1; wb0_need_to_wb = 1; wb0_prd = 6'd5; tick();
    check("B src1 woken while held", wide_t'(enq_src1_state), wide_t'(0));
    check("B still offered", wide_t'(enq_valid), wide_t'(1));
    wb0_valid = 0; enq_ready = 1; tick();

    // p9 is busy. C is accepted in the same cycle that wb1 writes p9.
    send(0, 0, 0, 0, 9, 1, 0, 3); tick();
    send(0, 0, 9, 1, 0, 0, 0, 4);
    wb1_valid = 1; wb1_need_to_wb = 1; wb1_prd = 6'd9; tick();
    check("C src2 same-cycle wakeup", wide_t'(enq_src2_state), wide_t'(0));
    wb1_valid = 0;

    // Three stalled cycles with C held.
    send(1, 1, 2, 1, 3, 1, 0, 5); enq_ready = 0; #1;
    check("stall in_ready", wide_t'(in_ready), wide_t'(0));
`ifdef DISPATCH_PERF_CNT_EN
    stall0 = perf_stall_cnt;
`endif
    repeat (3) begin
      tick();
      check("stall enq_prs2 stable", wide_t'(enq_prs2), wide_t'(9));
      check("stall enq_robidx stable", wide_t'(enq_robidx), wide_t'(4));
      check("stall in_ready", wide_t'(in_ready), wide_t'(0));
    end
`ifdef DISPATCH_PERF_CNT_EN
    check("stall counter +3", wide_t'(perf_stall_cnt), wide_t'(stall0 + 32'd3));
`endif
    enq_ready = 1; tick();
    in_valid = 0; tick();

    // Owners {0,3} on p11 and {0,12} on p12. G {0,10} is held when flush {0,7} hits.
    send(0, 0, 0, 0, 11, 1, 0, 3); tick();
    send(0, 0, 0, 0, 12, 1, 0, 12); tick();
    send(0, 0, 0, 0, 0, 0, 0, 10); tick();
    in_valid = 0; flush_valid = 1; flush_robidx_flag = 0; flush_robidx = 6'd7; #1;
    check("flush kills younger hold", wide_t'(enq_valid), wide_t'(0));
    check("flush blocks in_ready", wide_t'(in_ready), wide_t'(0));
    tick();
    flush_valid = 0; #1;
    check("hold cleared after flush", wide_t'(enq_valid), wide_t'(0));
    send(11, 1, 12, 1, 0, 0, 0, 13); tick();
    check("older owner p11 busy kept", wide_t'(enq_src1_state), wide_t'(1));
    check("younger owner p12 busy cleared", wide_t'(enq_src2_state), wide_t'(0));
    in_valid = 0; tick();

    // p0 is never busy. A same-cycle set and clear of p20 leaves p20 busy.
    send(0, 0, 0, 0, 0, 1, 0, 14); tick();
    send(0, 1, 0, 0, 0, 0, 0, 15); tick();
    check("p0 never busy", wide_t'(enq_src1_state), wide_t'(0));
    send(0, 0, 0, 0, 20, 1, 0, 16);
    wb0_valid = 1; wb0_need_to_wb = 1; wb0_prd = 6'd20; tick();
    wb0_valid = 0;
    send(20, 1, 0, 0, 20, 1, 0, 17); tick();
    check("p20 set wins over clear", wide_t'(enq_src1_state), wide_t'(1));
    in_valid = 0; tick();

    // Reset while an instruction is stalled in the hold entry.
    send(1, 0, 2, 0, 3, 0, 0, 18); enq_ready = 0; tick();
    in_valid = 0; #2;
    reset_n = 0; #1;
    check("async reset drops hold", wide_t'(enq_valid), wide_t'(0));
    @(negedge clock);
    reset_n = 1; in_valid = 1; #1;
    check("in_ready after reset release", wide_t'(in_ready), wide_t'(1));
    tick();
    idle(); tick();

    // Randomized traffic over a small preg range to force collisions.
    repeat (3000) begin
      rand_inputs();
      tick();
    end
    idle();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_stage.md
DISPATCH_STAGE -- requirements
Module: dispatch_stage

Interface
REQ-001 SHALL have parameter PREG_LOG, default 6, physical register index width (64 pregs).
REQ-002 SHALL have parameter ROB_LOG, default 6, ROB index width excluding wrap flag.
REQ-003 SHALL have parameter PAYLOAD_W, default 128, opaque decoded-instruction payload width, passed through unmodified.
REQ-004 SHALL have the following ports, one per line: name  direction  width  meaning.
- clock  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  renamed instruction valid
- in_ready  out  1  dispatch accepts the instruction this cycle
- in_prs1, in_prs2, in_prd  in  PREG_LOG each  physical sources and destination
- in_src1_is_reg, in_src2_is_reg, in_need_to_wb  in  1 each  source-is-register and writes-prd qualifiers
- in_robidx_flag / in_robidx  in  1 / ROB_LOG  ROB tag
- in_payload  in  PAYLOAD_W  opaque fields
- enq_valid  out  1  issue-queue enqueue valid
- enq_ready  in  1  issue-queue has a free slot
- enq_prs1, enq_prs2, enq_prd, enq_src1_is_reg, enq_src2_is_reg, enq_need_to_wb, enq_robidx_flag, enq_robidx, enq_payload  out  as inputs  registered copies
- enq_src1_state, enq_src2_state  out  1 each  1 = source still pending
- wb0_valid, wb0_need_to_wb, wb0_prd / wb1_*  in  1,1,PREG_LOG each  writeback wakeup ports
- flush_valid, flush_robidx_flag, flush_robidx  in  1,1,ROB_LOG  redirect flush

Function
REQ-005 SHALL hold one output register (hold entry), out_valid plus all enq_* fields.
REQ-006 in_ready SHALL be (~out_valid | enq_ready) & ~flush_valid.
REQ-007 Accept = in_valid & in_ready; on accept the hold entry SHALL load all in_* fields the following edge and out_valid SHALL be set.
REQ-008 Hold entry SHALL be cleared (out_valid=0) when enq handshake completes with no new accept.
REQ-009 Latency SHALL be exactly one cycle from accept to enq_valid.
REQ-010 A busy table of 2^PREG_LOG bits SHALL track pending pregs; preg 0 SHALL never be busy.
REQ-011 srcN_state on accept SHALL be busy[in_prsN] & in_srcN_is_reg & ~(wb0 wakeup hit) & ~(wb1 wakeup hit), where a hit means wbK_valid & wbK_need_to_wb & wbK_prd==in_prsN.
REQ-012 Busy lookup SHALL use the pre-update value; an instruction whose prs equals its own prd SHALL see the prior state.
REQ-013 On accept with in_need_to_wb=1 and in_prd!=0, busy[in_prd] SHALL be set and owner[in_prd] SHALL record {in_robidx_flag,in_robidx}.
REQ-014 Writeback with valid & need_to_wb SHALL clear busy[prd]; if set and clear target the same preg in the same cycle, set SHALL win.
REQ-015 While the hold entry waits, enq_srcN_state SHALL be cleared on every matching writeback, so no wakeup is lost before the issue queue sees the entry.
REQ-016 Younger(x) SHALL be (flush_flag ^ x_flag) ^ (flush_robidx < x_idx).
REQ-017 On flush_valid, enq_valid SHALL be combinationally 0 if the hold entry is younger, and out_valid SHALL clear next edge; an older hold entry SHALL be kept.
REQ-018 On flush_valid, every busy bit whose owner is younger SHALL be cleared; writeback clears in the same cycle SHALL still apply.
REQ-019 enq_valid SHALL otherwise equal out_valid; enq_* fields SHALL stay stable while enq_valid & ~enq_ready.

Reset
REQ-020 reset_n low SHALL asynchronously clear out_valid, all busy bits, enq_src1_state, enq_src2_state, and perf counters. Owner table and data fields are don't-care.
REQ-021 Reset mid-handshake SHALL drop the held instruction; in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-022 With DISPATCH_PERF_CNT_EN defined, the block SHALL add outputs perf_dispatch_cnt (32, increments per enq handshake) and perf_stall_cnt (32, increments per cycle with in_valid & ~in_ready). Both SHALL wrap modulo 2^32 and reset to 0.
REQ-023 Without DISPATCH_PERF_CNT_EN, those ports and registers SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-024 Dispatch A (prd=5, wb=1), then B (prs1=5): B enq_src1_state=1; wb0 prd=5 while B is held -> enq_src1_state=0 next cycle.
REQ-025 Accept C (prs2=9) with busy[9]=1 in the same cycle as wb1 prd=9 -> enq_src2_state=0.
REQ-026 enq_ready=0 for 3 cycles with the hold entry full -> in_ready=0, enq_* stable, perf_stall_cnt +3 if enabled.
REQ-027 Hold entry robidx {0,10}, flush {0,7} -> enq_valid=0 that cycle and out_valid=0 after; owner {0,3} busy bit kept, owner {0,12} cleared.
REQ-028 Accept with prd=0, need_to_wb=1, then consumer prs1=0 -> src1_state=0; same-cycle set/clear of preg 20 -> busy[20]=1.
